hadamard_scheduler: RTL and testbench
=====================================

# hadamard_scheduler

Two-requester scheduler in front of the single shared `complexhadamard` 4-lane twiddle-multiply/add unit. It grants the unit round-robin between two FFT stage controllers and captures the granted operands and tag. It pulses `start`, holds the operands stable until `hadamard_done`, and returns the result to the granting requester. A watchdog converts a missing `hadamard_done` into an error response so the requester never hangs.

## Interface
Parameters:
- `FORMAT_WIDTH`, 9: width of one SFP word. Must match the datapath `formatWidth`.
- `TAG_WIDTH`, 4: width of the opaque requester tag.
- `TIMEOUT`, 15: maximum number of WAIT cycles before the request aborts. Legal range 8..255.

Ports (reset `rst`, asynchronous, active-low; clock `clk`):
- `clk` in 1: clock.
- `rst` in 1: asynchronous active-low reset.
- `req_valid` in 2: request valid, one bit per requester i.
- `req_ready` out 2: request accepted, one bit per requester.
- `req_tag` in 2*TAG_WIDTH: tag, one slice per requester.
- `req_in_real`, `req_in_imag`, `req_tw_real`, `req_tw_imag` in 2*4*FORMAT_WIDTH each: operands. Requester i occupies slice i.
- `rsp_valid` out 2: response valid, per requester.
- `rsp_ready` in 2: response accepted, per requester.
- `rsp_real`, `rsp_imag` out 4*FORMAT_WIDTH: result, shared between requesters.
- `rsp_tag` out TAG_WIDTH: tag of the response.
- `rsp_err` out 1: the response was produced by timeout.
- `hd_start` out 1: start pulse to the datapath.
- `hd_input_real`, `hd_input_imag`, `hd_twiddle_real`, `hd_twiddle_imag` out 4*FORMAT_WIDTH: operands to the datapath.
- `hd_output_real`, `hd_output_imag` in 4*FORMAT_WIDTH: datapath results.
- `hd_done` in 1: datapath done.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- The FSM has five states: IDLE, LAUNCH, WAIT, RESP, and one reserved encoding. The reserved encoding goes to IDLE.
- **Arbitration (IDLE only):**
  - `sel` = the only valid requester. If both are valid, `sel` = the requester not granted last.
  - `req_ready[sel]` = 1 combinationally in IDLE when `req_valid[sel]`. Both `req_ready` bits are 0 outside IDLE.
  - On `req_valid & req_ready`: capture the operands and tag of `sel` into registers, set `gnt` = `sel`, set `last_grant` = `sel`, then go to LAUNCH.
- **LAUNCH:**
  - `hd_start` = 1 for exactly this one cycle.
  - Clear the watchdog counter, then go to WAIT.
- **WAIT:**
  - The counter increments every cycle.
  - If `hd_done` = 1, register `hd_output_real`/`hd_output_imag` into `rsp_real`/`rsp_imag`, set `rsp_err` = 0, then go to RESP.
  - Otherwise, if the counter = TIMEOUT-1, set `rsp_real`/`rsp_imag` = 0, set `rsp_err` = 1, then go to RESP.
  - If `hd_done` and the timeout coincide, `hd_done` wins.
- **RESP:**
  - `rsp_valid[gnt]` = 1. The other `rsp_valid` bit stays 0.
  - `rsp_tag`, `rsp_real`, `rsp_imag` and `rsp_err` are held stable until `rsp_ready[gnt]`.
  - On the handshake, go to IDLE.
  - `rsp_ready` of the non-granted requester is ignored.
- The `hd_*` operand outputs are driven from the captured registers and never change between LAUNCH and exit from WAIT. The datapath multipliers are combinational on these inputs, so this is required.
- `hd_done` is ignored in every state except WAIT.
- Reset values:
  - State IDLE, `last_grant` = 1, so requester 0 wins the first tie.
  - All outputs 0, including `hd_start`, operands, `rsp_*` and `busy`.
- Reset asserted mid-operation returns to IDLE immediately. No response is issued for the in-flight request. The datapath shares `rst` and resets in step.

## Timing
- Request handshake in cycle T:
  - T+1: LAUNCH, `hd_start` = 1.
  - T+2: WAIT.
  - The datapath asserts `hd_done` in T+6.
  - T+7: RESP with `rsp_valid` high.
- Nominal request-to-response latency is 7 cycles.
- A timeout response appears at T+2+TIMEOUT.
- Earliest next request acceptance is the cycle after the `rsp_ready` handshake. Peak throughput is one operation per 8 cycles.
- `req_ready` is combinational from `req_valid` and state. All other outputs are registered.

## Structure
- Shared package `hadamard_pkg` holds:
  - the state encoding constants (3 bits);
  - the default FORMAT_WIDTH/expWidth/sigWidth values, shared with `complexhadamard`;
  - the `hd_done` timeout default.
- One sub-module, `rr_arbiter_2`. It takes `req_valid[1:0]`, `last_grant` and an enable, and outputs a one-hot grant plus `sel`.
- The top level integrates the FSM, operand/response registers and watchdog. It instantiates `complexhadamard` only in the testbench.

## Test plan
- Only requester 0 is valid, with `tag` = 4'h3 and the unit model returning `hd_done` 5 cycles after `start`: `req_ready[0]` in T; `hd_start` for exactly 1 cycle at T+1; `rsp_valid[0]` at T+7 with `rsp_tag` = 3 and `rsp_err` = 0.
- Both requesters are held valid continuously: grants alternate 0,1,0,1 from reset, and each response goes only to the requester that was granted.
- `rsp_ready` is held low for 10 cycles in RESP: `rsp_*` stay stable, `busy` = 1, and a new `req_valid` gets no `req_ready`.
- `hd_done` is never asserted, with TIMEOUT = 15: the response arrives at T+17 with `rsp_err` = 1 and zero data. A stray `hd_done` in the next IDLE is ignored.
- The operands on `req_*` change during WAIT: `hd_input_*` and `hd_twiddle_*` keep the captured values.
- `rst` is pulsed low during WAIT: all outputs are 0 asynchronously, no response is produced, and the next request completes normally.

Source files
------------

// File: rtl/hadamard_pkg.sv
// rtl/hadamard_pkg.sv - shared constants and state encoding for the hadamard scheduler
package hadamard_pkg;

    localparam int EXP_WIDTH_DEFAULT    = 4;
    localparam int SIG_WIDTH_DEFAULT    = 4;
    localparam int FORMAT_WIDTH_DEFAULT = 1 + EXP_WIDTH_DEFAULT + SIG_WIDTH_DEFAULT;
    localparam int LANES                = 4;
    localparam int TAG_WIDTH_DEFAULT    = 4;
    localparam int HD_TIMEOUT_DEFAULT   = 15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RESP   = 3'd3,
        ST_RSVD   = 3'd4
    } hs_state_t;

endpackage

// File: rtl/hadamard_scheduler_if.sv
// rtl/hadamard_scheduler_if.sv - requester, response and datapath bundle of the hadamard scheduler
interface hadamard_scheduler_if #(
    parameter int FORMAT_WIDTH = hadamard_pkg::FORMAT_WIDTH_DEFAULT,
    parameter int TAG_WIDTH    = hadamard_pkg::TAG_WIDTH_DEFAULT
);
    localparam int W = hadamard_pkg::LANES * FORMAT_WIDTH;

    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [2*TAG_WIDTH-1:0] req_tag;
    logic [2*W-1:0]         req_in_real;
    logic [2*W-1:0]         req_in_imag;
    logic [2*W-1:0]         req_tw_real;
    logic [2*W-1:0]         req_tw_imag;

    logic [1:0]             rsp_valid;
    logic [1:0]             rsp_ready;
    logic [W-1:0]           rsp_real;
    logic [W-1:0]           rsp_imag;
    logic [TAG_WIDTH-1:0]   rsp_tag;
    logic                   rsp_err;

    logic                   hd_start;
    logic [W-1:0]           hd_input_real;
    logic [W-1:0]           hd_input_imag;
    logic [W-1:0]           hd_twiddle_real;
    logic [W-1:0]           hd_twiddle_imag;
    logic [W-1:0]           hd_output_real;
    logic [W-1:0]           hd_output_imag;
    logic                   hd_done;

    logic                   busy;

    modport slave (
        input  req_valid, req_tag, req_in_real, req_in_imag, req_tw_real, req_tw_imag,
        input  rsp_ready, hd_output_real, hd_output_imag, hd_done,
        output req_ready, rsp_valid, rsp_real, rsp_imag, rsp_tag, rsp_err,
        output hd_start, hd_input_real, hd_input_imag, hd_twiddle_real, hd_twiddle_imag, busy
    );

    modport master (
        output req_valid, req_tag, req_in_real, req_in_imag, req_tw_real, req_tw_imag,
        output rsp_ready, hd_output_real, hd_output_imag, hd_done,
        input  req_ready, rsp_valid, rsp_real, rsp_imag, rsp_tag, rsp_err,
        input  hd_start, hd_input_real, hd_input_imag, hd_twiddle_real, hd_twiddle_imag, busy
    );

endinterface

// File: rtl/hadamard_scheduler_arb.sv
// rtl/hadamard_scheduler_arb.sv - two-way round-robin arbiter
module rr_arbiter_2 (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       sel
);

    // Lone requester wins outright; on a tie the one not granted last wins.
    always_comb begin
        sel = req_valid[1];
        if (req_valid == 2'b11) begin
            sel = ~last_grant;
        end
        gnt = 2'b00;
        if (en && req_valid[sel]) begin
            gnt[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/hadamard_scheduler.sv
// rtl/hadamard_scheduler.sv - round-robin front end and watchdog for the shared complexhadamard unit
module hadamard_scheduler
    import hadamard_pkg::*;
#(
    parameter int FORMAT_WIDTH = FORMAT_WIDTH_DEFAULT,
    parameter int TAG_WIDTH    = TAG_WIDTH_DEFAULT,
    parameter int TIMEOUT      = HD_TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    hadamard_scheduler_if.slave  bus
);

    localparam int         W       = LANES * FORMAT_WIDTH;
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    hs_state_t            state;
    logic                 gnt;
    logic                 last_grant;
    logic                 sel;
    logic                 arb_en;
    logic                 accept;
    logic [1:0]           arb_gnt;
    logic [7:0]           wd_cnt;
    logic [TAG_WIDTH-1:0] sel_tag;
    logic [W-1:0]         sel_in_real;
    logic [W-1:0]         sel_in_imag;
    logic [W-1:0]         sel_tw_real;
    logic [W-1:0]         sel_tw_imag;

    // Arbitration is only open in IDLE; gating with rst keeps req_ready low during reset.
    assign arb_en = rst && (state == ST_IDLE);

    rr_arbiter_2 u_arb (
        .req_valid  (bus.req_valid),
        .last_grant (last_grant),
        .en         (arb_en),
        .gnt        (arb_gnt),
        .sel        (sel)
    );

    assign bus.req_ready = arb_gnt;
    assign accept        = |(bus.req_valid & arb_gnt);

    assign sel_tag     = sel ? bus.req_tag[2*TAG_WIDTH-1:TAG_WIDTH] : bus.req_tag[TAG_WIDTH-1:0];
    assign sel_in_real = sel ? bus.req_in_real[2*W-1:W] : bus.req_in_real[W-1:0];
    assign sel_in_imag = sel ? bus.req_in_imag[2*W-1:W] : bus.req_in_imag[W-1:0];
    assign sel_tw_real = sel ? bus.req_tw_real[2*W-1:W] : bus.req_tw_real[W-1:0];
    assign sel_tw_imag = sel ? bus.req_tw_imag[2*W-1:W] : bus.req_tw_imag[W-1:0];

    // Scheduler FSM: capture, launch, wait with watchdog, hold response until accepted.
    // Operand registers load only in IDLE, so hd_* stay fixed for the whole operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= ST_IDLE;
            gnt                 <= 1'b0;
            last_grant          <= 1'b1;
            wd_cnt              <= 8'd0;
            bus.hd_start        <= 1'b0;
            bus.hd_input_real   <= '0;
            bus.hd_input_imag   <= '0;
            bus.hd_twiddle_real <= '0;
            bus.hd_twiddle_imag <= '0;
            bus.rsp_valid       <= 2'b00;
            bus.rsp_real        <= '0;
            bus.rsp_imag        <= '0;
            bus.rsp_tag         <= '0;
            bus.rsp_err         <= 1'b0;
            bus.busy            <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        bus.hd_input_real   <= sel_in_real;
                        bus.hd_input_imag   <= sel_in_imag;
                        bus.hd_twiddle_real <= sel_tw_real;
                        bus.hd_twiddle_imag <= sel_tw_imag;
                        bus.rsp_tag         <= sel_tag;
                        gnt                 <= sel;
                        last_grant          <= sel;
                        bus.hd_start        <= 1'b1;
                        bus.busy            <= 1'b1;
                        state               <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    bus.hd_start <= 1'b0;
                    wd_cnt       <= 8'd0;
                    state        <= ST_WAIT;
                end
                ST_WAIT: begin
                    wd_cnt <= wd_cnt + 8'd1;
                    if (bus.hd_done) begin
                        bus.rsp_real  <= bus.hd_output_real;
                        bus.rsp_imag  <= bus.hd_output_imag;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_valid <= {gnt, ~gnt};
                        state         <= ST_RESP;
                    end else if (wd_cnt == WD_LAST) begin
                        bus.rsp_real  <= '0;
                        bus.rsp_imag  <= '0;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_valid <= {gnt, ~gnt};
                        state         <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready[gnt]) begin
                        bus.rsp_valid <= 2'b00;
                        bus.busy      <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    bus.hd_start  <= 1'b0;
                    bus.rsp_valid <= 2'b00;
                    bus.busy      <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hadamard_scheduler.sv
// tb/tb_hadamard_scheduler.sv - randomized scoreboard bench for hadamard_scheduler
module tb_hadamard_scheduler;
    import hadamard_pkg::*;

    localparam int FW = 9;
    localparam int TW = 4;
    localparam int TO = 15;
    localparam int W  = LANES * FW;

    typedef struct {
        logic [TW-1:0] tag;
        logic [W-1:0]  ir, ii, tr, ti;
    } req_t;

    typedef struct {
        int            who;
        logic [TW-1:0] tag;
        logic [W-1:0]  ir, ii, tr, ti, r, im;
        bit            err;
        int            arrive;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hadamard_scheduler_if #(.FORMAT_WIDTH(FW), .TAG_WIDTH(TW)) bus();

    hadamard_scheduler #(.FORMAT_WIDTH(FW), .TAG_WIDTH(TW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    req_t rq0[$];
    req_t rq1[$];
    exp_t exq[$];
    int   grant_log[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   hs_cyc = -100;
    int   last_pop_cyc = -100;
    int   rsp_done = 0;
    bit   hold_rsp = 0;
    int   dp_mode = 0;
    bit   stray = 0;
    bit   model_last = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h cyc=%0d", name, act, req, cyc);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        return W'({$urandom, $urandom});
    endfunction

    // Complex multiply per lane, truncated to the word width: stands in for complexhadamard.
    function automatic void lane_mul(input logic [W-1:0] ir, ii, tr, ti,
                                     output logic [W-1:0] r, im);
        int a, b, c, d;
        for (int l = 0; l < LANES; l++) begin
            a = int'(ir[l*FW +: FW]);
            b = int'(ii[l*FW +: FW]);
            c = int'(tr[l*FW +: FW]);
            d = int'(ti[l*FW +: FW]);
            r[l*FW +: FW]  = FW'(a * c - b * d);
            im[l*FW +: FW] = FW'(a * d + b * c);
        end
    endfunction

    function automatic req_t rand_req(input logic [TW-1:0] tag);
        req_t x;
        x.tag = tag;
        x.ir  = rnd();
        x.ii  = rnd();
        x.tr  = rnd();
        x.ti  = rnd();
        return x;
    endfunction

    task automatic check_zero(input string name);
        chk({name, "_ctrl"}, 64'({bus.req_ready, bus.rsp_valid, bus.rsp_tag, bus.rsp_err, bus.hd_start, bus.busy}), 64'd0);
        chk({name, "_rsp_real"}, 64'(bus.rsp_real), 64'd0);
        chk({name, "_rsp_imag"}, 64'(bus.rsp_imag), 64'd0);
        chk({name, "_hd_in"}, 64'(bus.hd_input_real | bus.hd_input_imag), 64'd0);
        chk({name, "_hd_tw"}, 64'(bus.hd_twiddle_real | bus.hd_twiddle_imag), 64'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((rq0.size() != 0 || rq1.size() != 0 || exq.size() != 0 || bus.busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_bound", 64'(n < 3000), 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3 rst = 1'b0;
        exq.delete();
        @(negedge clk);
        #3 rst = 1'b1;
    endtask

    // Requester model: checks arbitration, records accepted requests, drives both requesters.
    initial begin
        logic [1:0] want;
        exp_t       e;
        req_t       q;
        bus.req_valid   = 2'b00;
        bus.req_tag     = '0;
        bus.req_in_real = '0;
        bus.req_in_imag = '0;
        bus.req_tw_real = '0;
        bus.req_tw_imag = '0;
        bus.rsp_ready   = 2'b00;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                model_last = 1'b1;
            end else begin
                if (exq.size() != 0 || last_pop_cyc == cyc) want = 2'b00;
                else if (bus.req_valid == 2'b11) want = model_last ? 2'b01 : 2'b10;
                else want = bus.req_valid;
                chk("req_ready", 64'(bus.req_ready), 64'(want));
                for (int i = 0; i < 2; i++) begin
                    if (bus.req_valid[i] && bus.req_ready[i]) begin
                        q = (i == 0) ? rq0[0] : rq1[0];
                        if (i == 0) void'(rq0.pop_front()); else void'(rq1.pop_front());
                        e.who = i; e.tag = q.tag;
                        e.ir = q.ir; e.ii = q.ii; e.tr = q.tr; e.ti = q.ti;
                        if (dp_mode == 1) begin
                            e.err = 1'b1; e.r = '0; e.im = '0; e.arrive = cyc + 2 + TO;
                        end else begin
                            lane_mul(q.ir, q.ii, q.tr, q.ti, e.r, e.im);
                            e.err = 1'b0; e.arrive = cyc + 7;
                        end
                        exq.push_back(e);
                        grant_log.push_back(i);
                        model_last = i[0];
                        hs_cyc = cyc;
                    end
                end
            end
            @(posedge clk);
            #1;
            if (rst && rq0.size() != 0) begin
                bus.req_valid[0] = 1'b1;
                bus.req_tag[TW-1:0] = rq0[0].tag;
                bus.req_in_real[W-1:0] = rq0[0].ir; bus.req_in_imag[W-1:0] = rq0[0].ii;
                bus.req_tw_real[W-1:0] = rq0[0].tr; bus.req_tw_imag[W-1:0] = rq0[0].ti;
            end else begin
                bus.req_valid[0] = 1'b0;
                bus.req_tag[TW-1:0] = TW'($urandom);
                bus.req_in_real[W-1:0] = rnd(); bus.req_in_imag[W-1:0] = rnd();
                bus.req_tw_real[W-1:0] = rnd(); bus.req_tw_imag[W-1:0] = rnd();
            end
            if (rst && rq1.size() != 0) begin
                bus.req_valid[1] = 1'b1;
                bus.req_tag[2*TW-1:TW] = rq1[0].tag;
                bus.req_in_real[2*W-1:W] = rq1[0].ir; bus.req_in_imag[2*W-1:W] = rq1[0].ii;
                bus.req_tw_real[2*W-1:W] = rq1[0].tr; bus.req_tw_imag[2*W-1:W] = rq1[0].ti;
            end else begin
                bus.req_valid[1] = 1'b0;
                bus.req_tag[2*TW-1:TW] = TW'($urandom);
                bus.req_in_real[2*W-1:W] = rnd(); bus.req_in_imag[2*W-1:W] = rnd();
                bus.req_tw_real[2*W-1:W] = rnd(); bus.req_tw_imag[2*W-1:W] = rnd();
            end
            bus.rsp_ready = hold_rsp ? 2'b00 : 2'($urandom);
        end
    end

    // Datapath model: done five cycles after start (or never), plus an optional stray done.
    initial begin
        int         s;
        bit         pend;
        bit         nd;
        logic [W-1:0] r, im;
        s = 0; pend = 0; r = '0; im = '0;
        bus.hd_done = 1'b0;
        bus.hd_output_real = '0;
        bus.hd_output_imag = '0;
        forever begin
            @(negedge clk);
            nd = 0;
            if (!rst) begin
                pend = 0;
            end else begin
                if (pend && cyc == s + 4) begin nd = 1; pend = 0; end
                if (bus.hd_start) begin s = cyc; pend = (dp_mode == 0); end
                if (stray && !bus.busy) begin nd = 1; stray = 0; end
                lane_mul(bus.hd_input_real, bus.hd_input_imag, bus.hd_twiddle_real, bus.hd_twiddle_imag, r, im);
            end
            @(posedge clk);
            #1;
            bus.hd_done = nd;
            bus.hd_output_real = nd ? r : rnd();
            bus.hd_output_imag = nd ? im : rnd();
        end
    end

    // Monitor: launch timing and operand hold, response timing, routing, content and stability.
    initial begin
        logic          prev_start;
        logic [1:0]    prev_rv;
        logic [W-1:0]  lir, lii, ltr, lti, sr, si;
        logic [TW-1:0] st;
        logic          se;
        bit            in_op;
        prev_start = 0; prev_rv = 0; in_op = 0;
        lir = '0; lii = '0; ltr = '0; lti = '0; sr = '0; si = '0; st = '0; se = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_start = 0; prev_rv = 0; in_op = 0;
            end else begin
                if (bus.hd_start) begin
                    chk("hd_start_width", 64'(prev_start), 64'd0);
                    chk("hd_start_time", 64'(cyc), 64'(hs_cyc + 1));
                    if (exq.size() == 0) begin
                        chk("launch_without_request", 64'd0, 64'd1);
                    end else begin
                        chk("cap_in_real", 64'(bus.hd_input_real), 64'(exq[0].ir));
                        chk("cap_in_imag", 64'(bus.hd_input_imag), 64'(exq[0].ii));
                        chk("cap_tw_real", 64'(bus.hd_twiddle_real), 64'(exq[0].tr));
                        chk("cap_tw_imag", 64'(bus.hd_twiddle_imag), 64'(exq[0].ti));
                    end
                    lir = bus.hd_input_real; lii = bus.hd_input_imag;
                    ltr = bus.hd_twiddle_real; lti = bus.hd_twiddle_imag;
                    in_op = 1;
                end else if (in_op && bus.busy) begin
                    chk("hold_in_real", 64'(bus.hd_input_real), 64'(lir));
                    chk("hold_in_imag", 64'(bus.hd_input_imag), 64'(lii));
                    chk("hold_tw_real", 64'(bus.hd_twiddle_real), 64'(ltr));
                    chk("hold_tw_imag", 64'(bus.hd_twiddle_imag), 64'(lti));
                end
                if (!bus.busy) in_op = 0;
                if (bus.rsp_valid != 2'b00 && prev_rv == 2'b00) begin
                    if (exq.size() == 0) begin
                        chk("unexpected_rsp", 64'(bus.rsp_valid), 64'd0);
                    end else begin
                        chk("rsp_time", 64'(cyc), 64'(exq[0].arrive));
                        chk("rsp_route", 64'(bus.rsp_valid), (exq[0].who == 1) ? 64'd2 : 64'd1);
                        chk("rsp_tag", 64'(bus.rsp_tag), 64'(exq[0].tag));
                        chk("rsp_err", 64'(bus.rsp_err), 64'(exq[0].err));
                        chk("rsp_real", 64'(bus.rsp_real), 64'(exq[0].r));
                        chk("rsp_imag", 64'(bus.rsp_imag), 64'(exq[0].im));
                    end
                    sr = bus.rsp_real; si = bus.rsp_imag; st = bus.rsp_tag; se = bus.rsp_err;
                end else if (bus.rsp_valid != 2'b00) begin
                    chk("stable_valid", 64'(bus.rsp_valid), 64'(prev_rv));
                    chk("stable_data", 64'({bus.rsp_tag, bus.rsp_err} ^ {st, se}), 64'd0);
                    chk("stable_real", 64'(bus.rsp_real), 64'(sr));
                    chk("stable_imag", 64'(bus.rsp_imag), 64'(si));
                end
                if (bus.rsp_valid != 2'b00 && exq.size() != 0 && bus.rsp_ready[exq[0].who]) begin
                    void'(exq.pop_front());
                    rsp_done++;
                    last_pop_cyc = cyc;
                end
                prev_rv = bus.rsp_valid;
                prev_start = bus.hd_start;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int done0;
        rst = 1'b0;
        #3;
        check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        #3 rst = 1'b1;

        // Single request from requester 0, tag 3.
        rq0.push_back(rand_req(4'h3));
        wait_idle();

        // Both requesters continuously valid: grants alternate from reset.
        do_reset();
        grant_log.delete();
        for (int k = 0; k < 4; k++) begin
            rq0.push_back(rand_req(TW'($urandom)));
            rq1.push_back(rand_req(TW'($urandom)));
        end
        wait_idle();
        chk("grant_count", 64'(grant_log.size()), 64'd8);
        for (int k = 0; k < grant_log.size(); k++) chk("grant_order", 64'(grant_log[k]), 64'(k % 2));

        // Response held off for 10 cycles while another request waits.
        hold_rsp = 1;
        rq0.push_back(rand_req(TW'($urandom)));
        n = 0;
        while (!bus.rsp_valid[0] && n < 100) begin @(negedge clk); n++; end
        chk("hold_rsp_seen", 64'(bus.rsp_valid[0]), 64'd1);
        rq1.push_back(rand_req(TW'($urandom)));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #3;
            chk("hold_busy", 64'(bus.busy), 64'd1);
            chk("hold_no_ready", 64'(bus.req_ready), 64'd0);
            chk("hold_valid", 64'(bus.rsp_valid), 64'd1);
        end
        hold_rsp = 0;
        wait_idle();

        // Missing hd_done: watchdog response, then a stray hd_done in IDLE.
        dp_mode = 1;
        rq1.push_back(rand_req(TW'($urandom)));
        wait_idle();
        dp_mode = 0;
        stray = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("stray_idle", 64'({bus.busy, bus.rsp_valid}), 64'd0);
        end

        // Randomized mix of requests from both sides.
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 1) == 0) rq0.push_back(rand_req(TW'($urandom)));
            else rq1.push_back(rand_req(TW'($urandom)));
            repeat ($urandom_range(0, 10)) @(negedge clk);
        end
        wait_idle();

        // Reset during WAIT: outputs clear at once, nothing is answered, next request works.
        rq0.push_back(rand_req(TW'($urandom)));
        n = 0;
        while (!bus.hd_start && n < 100) begin @(negedge clk); n++; end
        chk("mid_launch_seen", 64'(bus.hd_start), 64'd1);
        repeat (2) @(negedge clk);
        #3 rst = 1'b0;
        #1;
        check_zero("mid_reset");
        exq.delete();
        @(negedge clk);
        #3 rst = 1'b1;
        done0 = rsp_done;
        rq1.push_back(rand_req(TW'($urandom)));
        wait_idle();
        chk("post_reset_done", 64'(rsp_done), 64'(done0 + 1));

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
